// File: rtl/l2_req_arbiter_if.sv
// Request/L2 bus bundle for the L2 request arbiter: instruction and data
// requester handshakes, the granted L2 request and the grant statistics.
interface l2_req_arbiter_if #(
    parameter int ADDR_W = 26
);
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic              d_req_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_src;
    logic              mem_ready;
    logic [31:0]       i_grants;
    logic [31:0]       d_grants;
    logic [31:0]       conflicts;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, mem_ready,
        output i_req_ready, d_req_ready, mem_valid, mem_addr, mem_we, mem_src,
        output i_grants, d_grants, conflicts
    );

    // Requester / L2 side
    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, mem_ready,
        input  i_req_ready, d_req_ready, mem_valid, mem_addr, mem_we, mem_src,
        input  i_grants, d_grants, conflicts
    );
endinterface

// File: rtl/l2_req_arbiter.sv
// L2 request arbiter: one holding buffer per requester, a registered output
// stage toward L2, data-priority arbitration with anti-starvation for
// instruction fills and same-line write-back ordering.
//
// state    | meaning
// ST_IDLE  | no request presented to L2 (mem_valid = 0)
// ST_ISSUE | request presented, held until mem_ready
module l2_req_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    l2_req_arbiter_if.slave    bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [0:0]        out_state;
    logic              i_full;
    logic [ADDR_W-1:0] i_addr;
    logic              d_full;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        starve;

    logic              i_ready;
    logic              d_ready;
    logic              out_free;
    logic              both_full;
    logic              same_line_wb;
    logic              pick_i;
    logic              load_out;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic              mem_src_q;
    logic [31:0]       i_grants_q;
    logic [31:0]       d_grants_q;
    logic [31:0]       conflicts_q;

    // Readiness comes straight from the buffer flags; reset masks it.
    always_comb begin
        i_ready = ~i_full & ~rst;
        d_ready = ~d_full & ~rst;
    end

    // Arbitration: single full buffer wins, then same-line write-back, then
    // starvation override, otherwise data.
    always_comb begin
        out_free     = (out_state == ST_IDLE) | bus.mem_ready;
        both_full    = i_full & d_full;
        same_line_wb = both_full & d_we & (d_addr == i_addr);
        pick_i       = 1'b0;
        if (i_full & ~d_full)
            pick_i = 1'b1;
        else if (both_full & ~same_line_wb & (starve == STARVE_MAX))
            pick_i = 1'b1;
        load_out = out_free & (i_full | d_full);
    end

    // Holding buffers: load on handshake, clear when moved to the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_full <= 1'b0;
            i_addr <= '0;
            d_full <= 1'b0;
            d_addr <= '0;
            d_we   <= 1'b0;
        end else begin
            if (bus.i_req_valid & i_ready) begin
                i_full <= 1'b1;
                i_addr <= bus.i_req_addr;
            end else if (load_out & pick_i) begin
                i_full <= 1'b0;
            end
            if (bus.d_req_valid & d_ready) begin
                d_full <= 1'b1;
                d_addr <= bus.d_req_addr;
                d_we   <= bus.d_req_we;
            end else if (load_out & ~pick_i) begin
                d_full <= 1'b0;
            end
        end
    end

    // Output stage: reload whenever free, otherwise hold the presented request.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state  <= ST_IDLE;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_src_q  <= 1'b0;
        end else if (load_out) begin
            out_state  <= ST_ISSUE;
            mem_addr_q <= pick_i ? i_addr : d_addr;
            mem_we_q   <= pick_i ? 1'b0 : d_we;
            mem_src_q  <= ~pick_i;
        end else if (out_free) begin
            out_state  <= ST_IDLE;
        end
    end

    // Starvation counter and grant/conflict statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve      <= '0;
            i_grants_q  <= '0;
            d_grants_q  <= '0;
            conflicts_q <= '0;
        end else begin
            if (load_out & pick_i) begin
                starve     <= '0;
                i_grants_q <= i_grants_q + 32'd1;
            end else if (load_out) begin
                d_grants_q <= d_grants_q + 32'd1;
                if (both_full && starve != STARVE_MAX)
                    starve <= starve + 4'd1;
            end
            if (out_free & both_full)
                conflicts_q <= conflicts_q + 32'd1;
        end
    end

    assign bus.i_req_ready = i_ready;
    assign bus.d_req_ready = d_ready;
    assign bus.mem_valid   = (out_state == ST_ISSUE);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_src     = mem_src_q;
    assign bus.i_grants    = i_grants_q;
    assign bus.d_grants    = d_grants_q;
    assign bus.conflicts   = conflicts_q;
endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares the single next-level (L2) request port between instruction-cache line fills and data-cache fills/write-backs.
- Each requester has a 1-entry holding buffer. A registered output stage holds the granted request stable until the L2 accepts it.
- Data requests have fixed priority. An anti-starvation counter and a same-line write-back ordering rule override that priority.
- Per-source grant and conflict statistics feed the statistics module.

Parameters:
ADDR_W, 26, line-address width (address bits [31:6]).
STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a waiting instruction request is forced through (1..15).

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
i_req_valid  in  1  instruction-cache fill request present
i_req_addr  in  ADDR_W  instruction fill line address
i_req_ready  out  1  instruction buffer can accept
d_req_valid  in  1  data-cache request present
d_req_addr  in  ADDR_W  data line address
d_req_we  in  1  1 = write-back, 0 = read fill
d_req_ready  out  1  data buffer can accept
mem_valid  out  1  request to L2 valid
mem_addr  out  ADDR_W  granted line address
mem_we  out  1  granted write flag (always 0 for instruction source)
mem_src  out  1  0 = instruction, 1 = data
mem_ready  in  1  L2 accepts current request
i_grants  out  32  instruction requests granted
d_grants  out  32  data requests granted
conflicts  out  32  arbitration cycles with both buffers full

Behaviour:
- Reset, with rst high at a posedge:
  - Both buffers empty; mem_valid=0, mem_addr=0, mem_we=0, mem_src=0.
  - All counters 0; starvation counter 0.
  - i_req_ready and d_req_ready are forced 0 while rst is high.
  - Requests presented during reset are discarded.
  - Reset mid-transaction drops any pending mem_valid without waiting for mem_ready.
- Buffers:
  - x_req_ready = ~x_full. It is registered, with no same-cycle bypass.
  - A buffer loads on x_req_valid & x_req_ready; x_full rises the next cycle.
  - A buffer clears on the cycle its entry moves to the output stage.
  - Minimum latency: accepted at edge N, mem_valid high after edge N+1.
- Output stage:
  - out_free = ~mem_valid | mem_ready.
  - When out_free is 1 and at least one buffer is full, the winner loads into mem_* and mem_valid=1.
  - When out_free is 1 and both buffers are empty, mem_valid goes to 0.
  - While mem_valid=1 and mem_ready=0, mem_addr, mem_we and mem_src are held stable.
  - Back-to-back issue (accept plus reload in the same cycle) is supported.
- Arbitration, evaluated only when out_free=1, in priority order:
  1. Only one buffer full: that buffer wins.
  2. Both full, d_we=1 and d_addr==i_addr: data wins. The write-back must precede the fetch of the same line; this overrides starvation.
  3. Both full and starvation counter == STARVE_LIMIT: instruction wins.
  4. Both full otherwise: data wins.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when both buffers are full and data wins.
  - Clears to 0 when instruction wins.
  - Holds otherwise.
- Statistics:
  - i_grants / d_grants increment by 1 on each load of the output stage from that source.
  - conflicts increments on each cycle with out_free=1 and both buffers full.
  - All three wrap modulo 2^32.
- No state machine beyond the buffer-full flags, mem_valid and the starvation counter. Output states are IDLE (mem_valid=0) and ISSUE (mem_valid=1). The transitions are those given by the output-stage rules above.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with i_req_valid=1 → readies 0, mem_valid stays 0, all counters 0. After release, i_req_ready=1.
- Single instruction fill: i_req_addr=26'h0123456 accepted at cycle 1, mem_ready=1 → mem_valid=1, mem_src=0, mem_addr=26'h0123456 at cycle 2, dropping at cycle 3. i_grants=1.
- L2 back-pressure: hold mem_ready=0 for 5 cycles with a data read 26'h00000AB issued → mem_* stable for all 5 cycles. d_req_ready returns 1 once its buffer has moved to the output stage. d_grants=1.
- Starvation override: keep both buffers refilled with distinct addresses (data reads), mem_ready=1, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,… The counter clears after the I grant, and conflicts counts every both-full cycle.
- Same-line write-back ordering: starvation counter at 4, i_addr = d_addr = 26'h0000F00 with d_req_we=1 → data granted first (mem_we=1, mem_src=1), then instruction (mem_we=0).
- Reset mid-operation: assert rst while mem_valid=1 and mem_ready=0 → mem_valid=0 after the edge, buffers empty, counters 0.
